// File: rtl/spi_xfer_sequencer_pkg.sv
// Shared constants for the SPI SFR sequencer: SFR address map, status/control bit
// positions and the sequencer state encoding.
package spi_xfer_sequencer_pkg;

  localparam logic [1:0] ADDR_CR1 = 2'b00;
  localparam logic [1:0] ADDR_CR2 = 2'b01;
  localparam logic [1:0] ADDR_BR  = 2'b10;
  localparam logic [1:0] ADDR_DR1 = 2'b11;

  localparam logic [2:0] ADDR_NONE = 3'b000;
  localparam logic [2:0] ADDR_SR   = 3'b011;
  localparam logic [2:0] ADDR_DR2  = 3'b101;

  localparam int SR_MDONE = 0;
  localparam int SR_SDONE = 1;
  localparam int SR_SSN   = 4;
  localparam int CR1_MSTR = 4;

  typedef enum logic [2:0] {
    ST_CFG_CR1,
    ST_CFG_BR,
    ST_IDLE,
    ST_LOAD,
    ST_POLL,
    ST_READ,
    ST_PUSH
  } state_e;

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Bundle of configuration, TX/RX stream and SFR bus signals around the sequencer.
// The master modport is the sequencer; the slave modport is its surroundings.
interface spi_xfer_sequencer_if;

  logic [7:0] cfg_cr1;
  logic [7:0] cfg_br;
  logic       cfg_load;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [1:0] sfraddr_w;
  logic       sfrwe;
  logic [7:0] spidata_o;
  logic [2:0] sfraddr_r;
  logic [7:0] sfr_data_i;
  logic       busy;
  logic       timeout;

  modport master (
    input  cfg_cr1, cfg_br, cfg_load, tx_valid, tx_data, rx_ready, sfr_data_i,
    output tx_ready, rx_valid, rx_data, sfraddr_w, sfrwe, spidata_o, sfraddr_r, busy, timeout
  );

  modport slave (
    output cfg_cr1, cfg_br, cfg_load, tx_valid, tx_data, rx_ready, sfr_data_i,
    input  tx_ready, rx_valid, rx_data, sfraddr_w, sfrwe, spidata_o, sfraddr_r, busy, timeout
  );

endinterface

// File: rtl/spi_xfer_sequencer_rd_wait.sv
// Read-latency down-counter: reloads when the SFR read address changes and reports
// when the registered read data reflects the new address.
module spi_xfer_sequencer_rd_wait #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expired_o
);

  localparam int CW = $clog2(RD_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(RD_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Host-side sequencer: programs CR1/BR, then for each TX byte writes DR1, polls SR
// for the done flag, reads DR2 and hands the result out on the RX stream.
module spi_xfer_sequencer #(
  parameter int TO_CYC = 4096,
  parameter int RD_LAT = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  spi_xfer_sequencer_if.master  bus_if
);

  import spi_xfer_sequencer_pkg::*;

  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TO_CYC - 1);

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic          seen_low_q, seen_low_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          sfrwe_q, sfrwe_d;
  logic [1:0]    waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [2:0]    raddr_q, raddr_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;
  logic          rd_expired;

  spi_xfer_sequencer_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (raddr_d != raddr_q),
    .expired_o (rd_expired)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | bus_if.cfg_load;
    seen_low_d = seen_low_q;
    tx_byte_d  = tx_byte_q;
    tmo_d      = tmo_q;
    timeout_d  = bus_if.cfg_load ? 1'b0 : timeout_q;
    rx_data_d  = rx_data_q;
    sfrwe_d    = 1'b0;
    waddr_d    = ADDR_CR1;
    wdata_d    = 8'h00;

    case (state_q)
      ST_CFG_CR1: begin
        sfrwe_d = 1'b1;
        waddr_d = ADDR_CR1;
        wdata_d = bus_if.cfg_cr1 | (8'h01 << CR1_MSTR);
        state_d = ST_CFG_BR;
      end
      ST_CFG_BR: begin
        sfrwe_d = 1'b1;
        waddr_d = ADDR_BR;
        wdata_d = bus_if.cfg_br;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = ST_CFG_CR1;
        end else if (bus_if.tx_valid && tx_ready_q) begin
          tx_byte_d = bus_if.tx_data;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sfrwe_d    = 1'b1;
        waddr_d    = ADDR_DR1;
        wdata_d    = tx_byte_q;
        seen_low_d = 1'b0;
        tmo_d      = '0;
        state_d    = ST_POLL;
      end
      ST_POLL: begin
        // A set flag only counts once it has been seen low, so a done bit left over
        // from the previous byte cannot end this transfer early.
        if (rd_expired) begin
          if (!bus_if.sfr_data_i[SR_MDONE]) begin
            seen_low_d = 1'b1;
          end else if (seen_low_q) begin
            state_d = ST_READ;
          end
        end
        if (state_d == ST_POLL) begin
          if (tmo_q == TMO_LAST) begin
            timeout_d = 1'b1;
            rx_data_d = 8'hFF;
            state_d   = ST_PUSH;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      ST_READ: begin
        if (rd_expired) begin
          rx_data_d = bus_if.sfr_data_i;
          state_d   = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (bus_if.rx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CFG_CR1;
    endcase

    if (state_d == ST_POLL) begin
      raddr_d = ADDR_SR;
    end else if (state_d == ST_READ) begin
      raddr_d = ADDR_DR2;
    end else begin
      raddr_d = ADDR_NONE;
    end

    tx_ready_d = (state_d == ST_IDLE) && !pend_d;
    rx_valid_d = (state_d == ST_PUSH);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CFG_CR1;
      pend_q     <= 1'b0;
      seen_low_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      sfrwe_q    <= 1'b0;
      waddr_q    <= ADDR_CR1;
      wdata_q    <= 8'h00;
      raddr_q    <= ADDR_NONE;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      seen_low_q <= seen_low_d;
      tx_byte_q  <= tx_byte_d;
      tmo_q      <= tmo_d;
      timeout_q  <= timeout_d;
      rx_data_q  <= rx_data_d;
      sfrwe_q    <= sfrwe_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus_if.tx_ready  = tx_ready_q;
  assign bus_if.rx_valid  = rx_valid_q;
  assign bus_if.rx_data   = rx_data_q;
  assign bus_if.sfraddr_w = waddr_q;
  assign bus_if.sfrwe     = sfrwe_q;
  assign bus_if.spidata_o = wdata_q;
  assign bus_if.sfraddr_r = raddr_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.timeout   = timeout_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a behavioural SFR block and
// scoreboards for the SFR write sequence and the RX byte stream.
module tb_spi_xfer_sequencer;

  import spi_xfer_sequencer_pkg::*;

  localparam int TO_CYC    = 64;
  localparam int RD_LAT    = 2;
  localparam int RISE_DLY  = 20;
  localparam int STALE_DLY = 5;
  localparam int FAR       = 1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if busIf ();

  spi_xfer_sequencer #(.TO_CYC(TO_CYC), .RD_LAT(RD_LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (busIf)
  );

  int compared = 0;
  int mismatched = 0;
  logic [9:0] expWrQ[$];
  logic [7:0] expRxQ[$];
  int sinceWrite = FAR;
  int sinceWriteAtRx = 0;
  int writeCount = 0;
  bit staleMode = 1'b0;
  bit neverRise = 1'b0;
  logic [7:0] dr2Value = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // SR[0] as the SPI core would show it, relative to the last DR1 write.
  function automatic logic srModel(input int s);
    if (neverRise) return 1'b0;
    if (staleMode && s < STALE_DLY) return 1'b1;
    return (s >= RISE_DLY);
  endfunction

  always @(posedge clk) begin
    if (busIf.sfrwe && busIf.sfraddr_w == ADDR_DR1) begin
      sinceWrite <= 0;
    end else if (sinceWrite < FAR) begin
      sinceWrite <= sinceWrite + 1;
    end
    case (busIf.sfraddr_r)
      ADDR_SR:  busIf.sfr_data_i <= {7'b0, srModel(sinceWrite)};
      ADDR_DR2: busIf.sfr_data_i <= dr2Value;
      default:  busIf.sfr_data_i <= 8'h00;
    endcase
  end

  initial forever begin
    logic [9:0] expWr;
    logic [7:0] expRx;
    @(negedge clk);
    if (busIf.sfrwe === 1'b1) begin
      writeCount++;
      checkOutput("sfrWriteExpected", 32'(expWrQ.size() != 0), 32'd1);
      if (expWrQ.size() != 0) begin
        expWr = expWrQ.pop_front();
        checkOutput("sfrWrite", 32'({busIf.sfraddr_w, busIf.spidata_o}), 32'(expWr));
      end
    end
    if (busIf.rx_valid === 1'b1 && busIf.rx_ready === 1'b1) begin
      sinceWriteAtRx = sinceWrite;
      checkOutput("rxExpected", 32'(expRxQ.size() != 0), 32'd1);
      if (expRxQ.size() != 0) begin
        expRx = expRxQ.pop_front();
        checkOutput("rxData", 32'(busIf.rx_data), 32'(expRx));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] txByte, input logic [7:0] rxByte);
    bit accepted;
    accepted = 1'b0;
    dr2Value = rxByte;
    expWrQ.push_back({ADDR_DR1, txByte});
    expRxQ.push_back(rxByte);
    busIf.tx_data  = txByte;
    busIf.tx_valid = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      if (busIf.tx_ready === 1'b1) accepted = 1'b1;
      tick(1);
    end
    busIf.tx_valid = 1'b0;
    checkOutput("txAccepted", 32'(accepted), 32'd1);
  endtask

  task automatic waitRxDrained(input int budget);
    for (int n = 0; n < budget && expRxQ.size() != 0; n++) tick(1);
    checkOutput("rxDelivered", 32'(expRxQ.size()), 32'd0);
  endtask

  initial begin
    bit rxHeld;
    bit txLow;
    int wc0;
    busIf.cfg_cr1  = 8'h23;
    busIf.cfg_br   = 8'h07;
    busIf.cfg_load = 1'b0;
    busIf.tx_valid = 1'b0;
    busIf.tx_data  = 8'h00;
    busIf.rx_ready = 1'b1;

    $display("[TB] reset and initial programming");
    repeat (2) @(negedge clk);
    checkOutput("rstSfrwe", 32'(busIf.sfrwe), 32'd0);
    checkOutput("rstAddrW", 32'(busIf.sfraddr_w), 32'd0);
    checkOutput("rstAddrR", 32'(busIf.sfraddr_r), 32'd0);
    checkOutput("rstRxData", 32'(busIf.rx_data), 32'd0);
    checkOutput("rstFlags", 32'({busIf.tx_ready, busIf.rx_valid, busIf.busy, busIf.timeout}), 32'd0);
    expWrQ.push_back({ADDR_CR1, 8'h33});
    expWrQ.push_back({ADDR_BR, 8'h07});
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    checkOutput("cr1Write", 32'({busIf.sfrwe, busIf.sfraddr_w, busIf.spidata_o}), 32'({1'b1, ADDR_CR1, 8'h33}));
    tick(1);
    checkOutput("brWrite", 32'({busIf.sfrwe, busIf.sfraddr_w, busIf.spidata_o}), 32'({1'b1, ADDR_BR, 8'h07}));
    tick(1);
    checkOutput("idleAfterCfg", 32'({busIf.sfrwe, busIf.tx_ready, busIf.busy}), 32'b010);

    $display("[TB] normal transfer");
    applyStimulus(8'hA5, 8'h3C);
    checkOutput("busyInFlight", 32'({busIf.busy, busIf.tx_ready}), 32'b10);
    waitRxDrained(300);
    checkOutput("rxAfterRise", 32'(sinceWriteAtRx >= RISE_DLY), 32'd1);
    checkOutput("noTimeout", 32'(busIf.timeout), 32'd0);

    $display("[TB] stale done flag");
    staleMode = 1'b1;
    applyStimulus(8'h5A, 8'hC3);
    waitRxDrained(300);
    checkOutput("staleNoEarly", 32'(sinceWriteAtRx >= RISE_DLY), 32'd1);
    staleMode = 1'b0;

    $display("[TB] poll timeout");
    neverRise = 1'b1;
    applyStimulus(8'h66, 8'hFF);
    waitRxDrained(300);
    checkOutput("timeoutDuration", 32'(sinceWriteAtRx >= TO_CYC - 4 && sinceWriteAtRx <= TO_CYC + 2), 32'd1);
    tick(3);
    checkOutput("timeoutSticky", 32'(busIf.timeout), 32'd1);
    neverRise = 1'b0;
    busIf.cfg_cr1 = 8'h41;
    busIf.cfg_br  = 8'h0F;
    expWrQ.push_back({ADDR_CR1, 8'h51});
    expWrQ.push_back({ADDR_BR, 8'h0F});
    busIf.cfg_load = 1'b1;
    tick(1);
    busIf.cfg_load = 1'b0;
    checkOutput("timeoutCleared", 32'(busIf.timeout), 32'd0);
    checkOutput("txReadyLoadPending", 32'(busIf.tx_ready), 32'd0);
    tick(4);

    $display("[TB] rx back-pressure");
    busIf.rx_ready = 1'b0;
    applyStimulus(8'h11, 8'h22);
    for (int n = 0; n < 300 && busIf.rx_valid !== 1'b1; n++) tick(1);
    checkOutput("rxValidRaised", 32'(busIf.rx_valid), 32'd1);
    wc0 = writeCount;
    rxHeld = 1'b1;
    txLow = 1'b1;
    busIf.tx_data  = 8'h99;
    busIf.tx_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick(1);
      if (busIf.rx_valid !== 1'b1) rxHeld = 1'b0;
      if (busIf.tx_ready !== 1'b0) txLow = 1'b0;
    end
    checkOutput("rxValidHeld", 32'(rxHeld), 32'd1);
    checkOutput("txReadyLowStalled", 32'(txLow), 32'd1);
    checkOutput("noWritesStalled", 32'(writeCount - wc0), 32'd0);
    checkOutput("rxDataHeld", 32'(busIf.rx_data), 32'h22);
    busIf.tx_valid = 1'b0;
    busIf.rx_ready = 1'b1;
    waitRxDrained(20);

    $display("[TB] cfg_load during poll");
    applyStimulus(8'h77, 8'h88);
    tick(4);
    checkOutput("busyDuringPoll", 32'(busIf.busy), 32'd1);
    busIf.cfg_cr1 = 8'h02;
    busIf.cfg_br  = 8'h03;
    expWrQ.push_back({ADDR_CR1, 8'h12});
    expWrQ.push_back({ADDR_BR, 8'h03});
    busIf.cfg_load = 1'b1;
    tick(1);
    busIf.cfg_load = 1'b0;
    waitRxDrained(300);
    applyStimulus(8'h44, 8'h55);
    waitRxDrained(300);
    checkOutput("noTimeoutAfterReload", 32'(busIf.timeout), 32'd0);

    tick(2);
    checkOutput("sfrWritesDrained", 32'(expWrQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
